// File: rtl/inst_fetch_resp_pkg.sv
// Shared types, constants and the address-check helper for the instruction fetch responder.
package inst_fetch_resp_pkg;

  typedef logic [31:0] inst_addr_t;
  typedef logic [31:0] inst_word_t;

  localparam logic       RST_ENABLE  = 1'b1;
  localparam logic       CHIP_ENABLE = 1'b1;
  localparam inst_word_t NOP_INST    = 32'h0000_0000;

  // A fetch is bad when it is not word aligned or lands above the word array.
  function automatic logic fetch_err(input inst_addr_t pc, input int unsigned depth_log2);
    return (pc[1:0] != 2'b00) || ((pc >> (depth_log2 + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/inst_fetch_resp_if.sv
// Fetch request/response bundle plus the side loader port.
// Handshake: a request is taken on a rising edge with ce=1 and stall=0; the
// response fields inst/inst_pc/addr_err are meaningful only while inst_valid=1,
// and stall=1 freezes both the request side and the response side.
interface inst_fetch_resp_if #(
  parameter int DEPTH_LOG2 = 10
);
  logic                  ce;
  logic [31:0]           pc;
  logic                  stall;
  logic [31:0]           inst;
  logic [31:0]           inst_pc;
  logic                  inst_valid;
  logic                  addr_err;
  logic                  ld_we;
  logic [DEPTH_LOG2-1:0] ld_addr;
  logic [31:0]           ld_data;

  modport master (
    output ce, pc, stall, ld_we, ld_addr, ld_data,
    input  inst, inst_pc, inst_valid, addr_err
  );

  modport slave (
    input  ce, pc, stall, ld_we, ld_addr, ld_data,
    output inst, inst_pc, inst_valid, addr_err
  );
endinterface

// File: rtl/inst_fetch_resp_mem_array.sv
// Word array with one write port and a registered read port; the read
// register is the first stage of the fetch pipeline.
module inst_mem_array #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_idx,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_idx,
  input  logic [31:0]           wr_data,
  output logic [31:0]           rd_data
);

  logic [31:0] mem [2**DEPTH_LOG2];

  // Loader write; never gated by reset or stall.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  // Registered read; a same-edge write to the same index is seen next time.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/inst_fetch_resp.sv
// Instruction memory responder: returns the word at pc after READ_LAT edges,
// tagged with its pc and an address error flag.
module inst_fetch_resp
  import inst_fetch_resp_pkg::*;
#(
  parameter int         DEPTH_LOG2 = 10,
  parameter int         READ_LAT   = 2,
  parameter inst_word_t NOP_WORD   = NOP_INST
) (
  input  logic               clk,
  input  logic               rst,
  inst_fetch_resp_if.slave   fetch
);

  logic                  accept;
  logic                  req_err;
  logic                  rd_en;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [31:0]           rd_data;
  logic [31:0]           out_word;

  logic [READ_LAT-1:0]   vld_q;
  logic [READ_LAT-1:0]   err_q;
  logic [31:0]           pc_q [READ_LAT];

  assign accept  = !fetch.stall && (fetch.ce == CHIP_ENABLE);
  assign req_err = fetch_err(fetch.pc, DEPTH_LOG2);
  assign rd_en   = accept && !req_err;
  assign rd_idx  = fetch.pc[DEPTH_LOG2+1:2];

  inst_mem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
    .clk     (clk),
    .rd_en   (rd_en),
    .rd_idx  (rd_idx),
    .wr_en   (fetch.ld_we),
    .wr_idx  (fetch.ld_addr),
    .wr_data (fetch.ld_data),
    .rd_data (rd_data)
  );

  // Valid/err/pc stage shift; pc only follows valid entries so bubbles keep the last pc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      vld_q <= '0;
      err_q <= '0;
      for (int i = 0; i < READ_LAT; i++) pc_q[i] <= '0;
    end else if (!fetch.stall) begin
      vld_q[0] <= accept;
      err_q[0] <= accept && req_err;
      if (accept) pc_q[0] <= fetch.pc;
      for (int i = 1; i < READ_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        err_q[i] <= err_q[i-1];
        if (vld_q[i-1]) pc_q[i] <= pc_q[i-1];
      end
    end
  end

  // Data words beyond the array read register; validity is tracked by vld_q.
  generate
    if (READ_LAT > 1) begin : g_word_pipe
      logic [31:0] word_q [READ_LAT-1];

      // Word shift for stages 2..READ_LAT.
      always_ff @(posedge clk) begin
        if (!fetch.stall) begin
          word_q[0] <= rd_data;
          for (int i = 1; i < READ_LAT - 1; i++) word_q[i] <= word_q[i-1];
        end
      end

      assign out_word = word_q[READ_LAT-2];
    end else begin : g_word_direct
      assign out_word = rd_data;
    end
  endgenerate

  // Output muxing: bubbles and errors present the NOP word.
  always_comb begin
    fetch.inst_valid = vld_q[READ_LAT-1];
    fetch.addr_err   = vld_q[READ_LAT-1] && err_q[READ_LAT-1];
    fetch.inst_pc    = pc_q[READ_LAT-1];
    fetch.inst       = NOP_WORD;
    if (vld_q[READ_LAT-1] && !err_q[READ_LAT-1]) fetch.inst = out_word;
  end

endmodule

// File: doc/inst_fetch_resp.md
Name: inst_fetch_resp

Overview:
Instruction-memory responder on the far end of the fetch interface. It consumes the fetch address and chip-enable produced by the PC generator and returns the addressed instruction word after a fixed, parameterised read latency, tagged with its PC and an error flag. Storage is an internal word array filled through a side loader port by the testbench or boot logic. Downstream, the IF/ID pipeline register consumes its outputs.

Parameters:
DEPTH_LOG2, 10, number of words is 2**DEPTH_LOG2 (word-addressed storage).
READ_LAT, 2, cycles from request edge to output; legal range 1..4.
NOP_WORD, 32'h00000000, word driven on error or bubble.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
ce  in  1  fetch request enable; a request is accepted at a rising edge when ce=1 and stall=0.
pc  in  32  byte address of the requested instruction.
stall  in  1  freezes the read pipeline and outputs.
inst  out  32  returned instruction word.
inst_pc  out  32  PC that produced inst.
inst_valid  out  1  inst/inst_pc/addr_err are meaningful.
addr_err  out  1  request was misaligned or out of range.
ld_we  in  1  loader write strobe.
ld_addr  in  DEPTH_LOG2  loader word index.
ld_data  in  32  loader write data.

Behaviour:
- Reset (async, rst=1): all pipeline valid bits cleared. inst=NOP_WORD, inst_pc=0, inst_valid=0, addr_err=0. Memory contents are not reset.
- Request acceptance: at an edge with ce=1 and stall=0, the block captures pc into stage 1. With ce=0 (and stall=0), a bubble (valid=0) enters stage 1.
- Word index: pc[DEPTH_LOG2+1:2].
- Error:
  - Misaligned when pc[1:0]!=0.
  - Out of range when any pc[31:DEPTH_LOG2+2] bit is 1.
  - Either condition sets the stage err bit. The returned word is then NOP_WORD and the array is not read.
- Latency:
  - A request accepted at edge N appears on the outputs after edge N+READ_LAT-1.
  - It is visible during the cycle following that edge; READ_LAT=1 means it is visible in the cycle right after acceptance.
  - Each stage carries valid, pc, err and the word.
- Output on a bubble: when the output stage valid=0, inst=NOP_WORD, addr_err=0, and inst_pc holds its last value.
- Stall: while stall=1, no stage advances, ce is ignored and outputs hold exactly. Stall has no effect on the loader.
- Loader: on an edge with ld_we=1, mem[ld_addr] is written with ld_data. A fetch of the same index on the same edge returns the OLD word (read-before-write). Loader writes are accepted in every state, including reset.
- Back-to-back: one request per cycle sustained; there are no internal bubbles.
- Reset mid-operation: in-flight requests are discarded and no partial output is produced. After rst deasserts, the first valid output appears READ_LAT cycles after the first accepted request.
- pc arithmetic: no wrap handling is needed; addresses at or above 4*2**DEPTH_LOG2 are simply errors.

Decomposition:
- Shared defines include: `InstAddrBus (31:0), `InstBus (31:0), `RstEnable (1'b1), `ChipEnable (1'b1), `ChipDisable (1'b0), `NopInst (32'h0).
- Sub-module inst_mem_array:
  - Synchronous-read, single-write-port word array.
  - Inputs: rd_en, rd_idx, wr_en, wr_idx, wr_data.
  - Output: registered rd_data, which forms stage 1 of the read pipeline.
- The top level holds the stage registers for valid, pc and err and the error/NOP muxing.

Test Plan:
- Normal fetch: preload mem[0..3]=32'h11111111, 22222222, 33333333, 44444444; release reset; ce=1 with pc=0, 4, 8, 0xC on consecutive edges. Required: after 2 edges, inst_valid=1 with inst in that order, inst_pc=0, 4, 8, 0xC, addr_err=0, one word per cycle.
- Error cases: pc=0x6 gives inst=0, addr_err=1, inst_pc=0x6. pc=0x1000 (DEPTH_LOG2=10) gives inst=0, addr_err=1.
- Stall: stream pc=0, 4, 8 and assert stall for 3 cycles mid-stream. Required: outputs frozen during the stall, no request lost or duplicated, and the sequence resumes 0, 4, 8.
- ce gaps: ce pattern 1,0,1 with pc=0, 4, 8. Required: outputs are valid pc=0, then a bubble (inst_valid=0, inst=0), then valid pc=8.
- Collision: mem[2]=0xAAAA0000; write ld_data=0xBBBB0000 to index 2 on the same edge as a fetch of pc=8. Required: that fetch returns 0xAAAA0000, and the next fetch of pc=8 returns 0xBBBB0000.
- Reset mid-stream: assert rst asynchronously between edges with two requests in flight. Required: inst_valid drops to 0 immediately, inst=0, and neither in-flight request is ever output. Repeat with READ_LAT=1 and READ_LAT=4.
